riscv_lsu: RTL
==============

// Module: riscv_lsu
// PURPOSE
//  Load/store unit between the core datapath and ext_mem (data memory).
//  Converts core loads/stores (size from funct3) into word-addressed
//  requests with byte enables and lane-replicated write data.
//  Sign/zero-extends returned read data and stalls the core until ext_mem
//  completes. Flags misaligned or illegal-size accesses instead of issuing them.
// PARAMETERS
//  none. Size encodings come from lsu_pkg.
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous, active-high reset
//  core_req_i     in   1   core requests a load/store; held until stall drops
//  core_we_i      in   1   1 = store, 0 = load
//  core_size_i    in   3   funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
//  core_addr_i    in   32  byte address
//  core_wd_i      in   32  store data, right-aligned
//  core_rd_o      out  32  load result, extended; valid in the cycle stall drops
//  core_stall_o   out  1   1 = hold the pipeline
//  lsu_err_o      out  1   1-cycle pulse: misaligned or illegal size; no access
//  mem_req_o      out  1   request to ext_mem
//  mem_we_o       out  1   write enable to ext_mem
//  mem_be_o       out  4   byte enables
//  mem_addr_o     out  32  core_addr_i passed through; ext_mem uses [13:2]
//  mem_wd_o       out  32  lane-replicated store data
//  mem_rd_i       in   32  registered read word from ext_mem
//  mem_ready_i    in   1   ext_mem completion
// BEHAVIOUR
//  - FSM: IDLE, ACCESS. Reset -> IDLE. All outputs 0 in reset and in IDLE
//    with no request.
//  - IDLE, core_req_i=1, legal access:
//    - Drive mem_req_o=1, mem_we_o=core_we_i, mem_be_o and mem_wd_o.
//    - core_stall_o=1.
//    - Register addr[1:0] and core_size_i. Next state ACCESS.
//  - IDLE, core_req_i=1, illegal access:
//    - Illegal means size in {3,6,7}, half with addr[0]=1, or word with addr[1:0]!=0.
//    - mem_req_o=0, lsu_err_o=1, core_stall_o=0. Stay in IDLE.
//  - ACCESS:
//    - mem_req_o=0.
//    - mem_ready_i=0: core_stall_o=1, stay in ACCESS.
//    - mem_ready_i=1: core_stall_o=0, core_rd_o valid (loads), next IDLE.
//  - Latency: 2 cycles per access with ext_mem. The core sees stall for exactly 1 cycle.
//  - Byte enables:
//    - B: 4'b0001 << addr[1:0]
//    - H: addr[1] ? 4'b1100 : 4'b0011
//    - W: 4'b1111
//  - Write data:
//    - B: {4{wd[7:0]}}
//    - H: {2{wd[15:0]}}
//    - W: wd
//  - Read:
//    - Select the byte or halfword by the registered offset.
//    - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
//    - Uses registered offset/size, never live core inputs.
//  - core_rd_o = 0 outside the completing cycle and for stores.
//  - Back-to-back: a new core_req_i in the cycle after completion starts a
//    fresh access from IDLE. No pipelining of two accesses.
//  - Reset mid-ACCESS: return to IDLE, drop stall, discard the pending result.
//    A store already issued stays written.
// STRUCTURE
//  - lsu_pkg:
//    - size localparams: LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2,
//      LDST_BU=3'd4, LDST_HU=3'd5
//    - typedef enum logic {IDLE, ACCESS} lsu_state_t
//  - Sub-module lsu_load_extend (combinational): word, offset, size -> core_rd.
//    Reused by the bench as its model.
// TESTING
//  - SW 0xDEADBEEF @0x10 -> be=1111, wd=0xDEADBEEF, stall 1 cycle.
//    Then LW @0x10 -> rd=0xDEADBEEF.
//  - SB 0x1234_5680 @0x13 -> be=1000, wd=0x80808080.
//    LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
//  - SH 0x0000_8001 @0x22 -> be=1100, wd=0x80018001.
//    LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001.
//  - LW @0x11, LH @0x21, size=3 @0x0 -> lsu_err_o pulse,
//    mem_req_o=0, stall=0, memory unchanged.
//  - Hold mem_ready_i=0 for 3 cycles in ACCESS -> stall stays 1,
//    mem_req_o=0; releases on the ready cycle with correct data.
//  - Assert rst_i in ACCESS -> next cycle IDLE, stall=0, rd=0.
//    A following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the alignment rule that decides whether an access may be issued.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {IDLE, ACCESS} lsu_state_t;

  function automatic logic access_legal(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B, LDST_BU: ok = 1'b1;
      LDST_H, LDST_HU: ok = ~off[0];
      LDST_W:          ok = (off == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and ext_mem-side signals of the load/store unit.
// slave is the LSU view; master is the core plus memory environment.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
           mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, lsu_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
           mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, lsu_err_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load size.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] rd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    rd = '0;
    case (size)
      LDST_B:  rd = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rd = {24'h0, byte_sel};
      LDST_H:  rd = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rd = {16'h0, half_sel};
      LDST_W:  rd = word;
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues one aligned word-addressed access per core request,
// stalls until ext_mem answers, and flags misaligned or illegal-size accesses.
//
//   state  | meaning
//   IDLE   | no access outstanding; a legal request is issued this cycle
//   ACCESS | request issued, waiting for mem_ready_i
module riscv_lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  riscv_lsu_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        issue;
  logic [31:0] load_word;

  lsu_load_extend u_load_extend (
    .word (bus.mem_rd_i),
    .off  (off_q),
    .size (size_q),
    .rd   (load_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        off_q  <= bus.core_addr_i[1:0];
        size_q <= bus.core_size_i;
        we_q   <= bus.core_we_i;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted so a pending result is discarded.
  always_comb begin
    state_d          = state_q;
    issue            = 1'b0;
    bus.core_rd_o    = '0;
    bus.core_stall_o = 1'b0;
    bus.lsu_err_o    = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_be_o     = 4'b0000;
    bus.mem_addr_o   = '0;
    bus.mem_wd_o     = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (bus.core_req_i) begin
            if (access_legal(bus.core_size_i, bus.core_addr_i[1:0])) begin
              issue            = 1'b1;
              state_d          = ACCESS;
              bus.core_stall_o = 1'b1;
              bus.mem_req_o    = 1'b1;
              bus.mem_we_o     = bus.core_we_i;
              bus.mem_addr_o   = bus.core_addr_i;
              case (bus.core_size_i[1:0])
                2'b00: begin
                  bus.mem_be_o = 4'b0001 << bus.core_addr_i[1:0];
                  bus.mem_wd_o = {4{bus.core_wd_i[7:0]}};
                end
                2'b01: begin
                  bus.mem_be_o = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
                  bus.mem_wd_o = {2{bus.core_wd_i[15:0]}};
                end
                default: begin
                  bus.mem_be_o = 4'b1111;
                  bus.mem_wd_o = bus.core_wd_i;
                end
              endcase
            end else begin
              bus.lsu_err_o = 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ready_i) begin
            state_d = IDLE;
            if (!we_q) bus.core_rd_o = load_word;
          end else begin
            bus.core_stall_o = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
